// File: rtl/sequenciador_mensagem_ascii.sv
// Sends an N-character message one character at a time through a serial TX, with a GAP-cycle idle between characters.
// Moore FSM: outputs are decoded from the registered state; tx_pronto only advances from ESPERA, and parar aborts any busy state.
module sequenciador_mensagem_ascii #(
  parameter int N   = 8,
  parameter int GAP = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 parar,
  input  logic                 tx_pronto,
  output logic                 partida_tx,
  output logic [$clog2(N)-1:0] indice,
  output logic                 ocupado,
  output logic                 pronto,
  output logic [3:0]           db_estado
);

  localparam int IW     = $clog2(N);
  localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_M1);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    DISPARA   = 4'd2,
    ESPERA    = 4'd3,
    INTERVALO = 4'd4,
    PROXIMO   = 4'd5,
    FINAL     = 4'd6
  } t_estado;

  t_estado       r_estado;
  logic [IW-1:0] r_indice;
  logic [GW-1:0] r_gap;

  logic w_ultimo;
  logic w_fim_gap;
  logic w_ocupado;

  assign w_ultimo  = (r_indice == IDX_LAST);
  assign w_fim_gap = (r_gap == GAP_LAST);
  assign w_ocupado = (r_estado == PREPARA)   || (r_estado == DISPARA) ||
                     (r_estado == ESPERA)    || (r_estado == INTERVALO) ||
                     (r_estado == PROXIMO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
      r_indice <= '0;
      r_gap    <= '0;
    end else if (parar && w_ocupado) begin
      r_estado <= INICIAL;
      r_indice <= '0;
      r_gap    <= '0;
    end else begin
      case (r_estado)
        INICIAL: begin
          if (iniciar) r_estado <= PREPARA;
        end
        PREPARA: begin
          r_indice <= '0;
          r_gap    <= '0;
          r_estado <= DISPARA;
        end
        DISPARA: begin
          r_estado <= ESPERA;
        end
        ESPERA: begin
          // The last character ends the message before indice can move past N-1.
          if (tx_pronto) begin
            if (w_ultimo)     r_estado <= FINAL;
            else if (GAP > 0) r_estado <= INTERVALO;
            else              r_estado <= PROXIMO;
          end
        end
        INTERVALO: begin
          if (w_fim_gap) begin
            r_gap    <= '0;
            r_estado <= PROXIMO;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        PROXIMO: begin
          r_indice <= r_indice + 1'b1;
          r_estado <= DISPARA;
        end
        FINAL: begin
          r_estado <= INICIAL;
        end
        default: begin
          r_estado <= INICIAL;
        end
      endcase
    end
  end

  assign partida_tx = (r_estado == DISPARA);
  assign pronto     = (r_estado == FINAL);
  assign ocupado    = w_ocupado;
  assign indice     = r_indice;
  assign db_estado  = r_estado;

endmodule

// File: tb/tb_sequenciador_mensagem_ascii.sv
// Directed bench: one instance with N=8/GAP=2 and one with N=3/GAP=0, driven by per-scenario tasks.
module tb_sequenciador_mensagem_ascii;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: N=8, GAP=2
  logic       a_rst = 1'b0, a_ini = 1'b0, a_par = 1'b0, a_txp = 1'b0;
  logic       a_part, a_ocup, a_pronto;
  logic [2:0] a_idx;
  logic [3:0] a_db;

  // Instance B: N=3, GAP=0
  logic       b_rst = 1'b0, b_ini = 1'b0, b_par = 1'b0, b_txp = 1'b0;
  logic       b_part, b_ocup, b_pronto;
  logic [1:0] b_idx;
  logic [3:0] b_db;

  sequenciador_mensagem_ascii #(.N(8), .GAP(2)) dut_a (
    .clock(clock), .reset(a_rst), .iniciar(a_ini), .parar(a_par), .tx_pronto(a_txp),
    .partida_tx(a_part), .indice(a_idx), .ocupado(a_ocup), .pronto(a_pronto), .db_estado(a_db)
  );

  sequenciador_mensagem_ascii #(.N(3), .GAP(0)) dut_b (
    .clock(clock), .reset(b_rst), .iniciar(b_ini), .parar(b_par), .tx_pronto(b_txp),
    .partida_tx(b_part), .indice(b_idx), .ocupado(b_ocup), .pronto(b_pronto), .db_estado(b_db)
  );

  int seq_b [11] = '{1, 2, 3, 5, 2, 3, 5, 2, 3, 6, 0};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b0; b_rst = 1'b0;
    tick(); tick();
    checks++;
    if ({a_part, a_ocup, a_pronto, a_idx, a_db} !== 10'd0) begin
      errors++; $display("FAIL reset_a: got %b expected 0", {a_part, a_ocup, a_pronto, a_idx, a_db});
    end
    checks++;
    if ({b_part, b_ocup, b_pronto, b_idx, b_db} !== 9'd0) begin
      errors++; $display("FAIL reset_b: got %b expected 0", {b_part, b_ocup, b_pronto, b_idx, b_db});
    end
    a_rst = 1'b1; b_rst = 1'b1;
    tick();
    checks++;
    if (a_db !== 4'd0) begin
      errors++; $display("FAIL idle_after_reset: db_estado got %0d expected 0", a_db);
    end
  endtask

  task automatic test_full_message();
    int np = 0, last = 0, cyc = 0;
    bit done = 0;
    a_ini = 1'b1;
    tick();
    a_ini = 1'b0;
    while (!done && cyc < 300) begin
      cyc++;
      if (a_part) begin
        checks++;
        if (a_idx !== 3'(np)) begin
          errors++; $display("FAIL full_indice: got %0d expected %0d", a_idx, np);
        end
        if (np > 0) begin
          checks++;
          if (cyc - last != 14) begin
            errors++; $display("FAIL full_spacing: got %0d expected 14", cyc - last);
          end
        end
        np++;
        last = cyc;
      end
      if (a_pronto) begin
        done = 1;
        checks++;
        if (cyc - last != 11) begin
          errors++; $display("FAIL full_pronto_delay: got %0d expected 11", cyc - last);
        end
        checks++;
        if (a_ocup !== 1'b0) begin
          errors++; $display("FAIL full_ocupado_at_pronto: got %b expected 0", a_ocup);
        end
      end
      a_txp = (np > 0) && (cyc == last + 10);
      if (!done) tick();
    end
    a_txp = 1'b0;
    checks++;
    if (!done || np != 8) begin
      errors++; $display("FAIL full_count: pulses %0d done %0d expected 8 1", np, done);
    end
    tick();
    checks++;
    if (a_pronto !== 1'b0 || a_db !== 4'd0) begin
      errors++; $display("FAIL full_pronto_width: pronto %b db %0d expected 0 0", a_pronto, a_db);
    end
  endtask

  task automatic test_zero_gap();
    int ndisp = 0;
    b_txp = 1'b1;
    b_ini = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      b_ini = 1'b0;
      checks++;
      if (b_db !== 4'(seq_b[i])) begin
        errors++; $display("FAIL zero_gap_state[%0d]: got %0d expected %0d", i, b_db, seq_b[i]);
      end
      checks++;
      if (b_part !== (seq_b[i] == 2) || b_pronto !== (seq_b[i] == 6)) begin
        errors++; $display("FAIL zero_gap_pulses[%0d]: partida %b pronto %b for state %0d", i, b_part, b_pronto, seq_b[i]);
      end
      if (seq_b[i] == 2) begin
        checks++;
        if (b_idx !== 2'(ndisp)) begin
          errors++; $display("FAIL zero_gap_indice: got %0d expected %0d", b_idx, ndisp);
        end
        ndisp++;
      end
    end
    b_txp = 1'b0;
  endtask

  task automatic test_early_tx_pronto();
    int n = 0;
    a_ini = 1'b1;
    tick();
    a_ini = 1'b0;
    while (a_db !== 4'd2 && n < 20) begin tick(); n++; end
    checks++;
    if (a_db !== 4'd2) begin
      errors++; $display("FAIL early_reach_dispara: got %0d expected 2", a_db);
    end
    a_txp = 1'b1;
    tick();
    a_txp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_db !== 4'd3 || a_idx !== 3'd0) begin
        errors++; $display("FAIL early_hold[%0d]: db %0d idx %0d expected 3 0", i, a_db, a_idx);
      end
      if (i < 4) tick();
    end
    a_txp = 1'b1;
    tick();
    a_txp = 1'b0;
    checks++;
    if (a_db !== 4'd4 || a_idx !== 3'd0) begin
      errors++; $display("FAIL early_release: db %0d idx %0d expected 4 0", a_db, a_idx);
    end
    a_par = 1'b1;
    tick();
    a_par = 1'b0;
    checks++;
    if (a_db !== 4'd0) begin
      errors++; $display("FAIL early_cleanup_abort: db %0d expected 0", a_db);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int seen_pronto = 0;
    a_txp = 1'b1;
    a_ini = 1'b1;
    tick();
    a_ini = 1'b0;
    while (!(a_db == 4'd4 && a_idx == 3'd3) && n < 200) begin
      if (a_pronto) seen_pronto++;
      tick(); n++;
    end
    checks++;
    if (a_db !== 4'd4 || a_idx !== 3'd3) begin
      errors++; $display("FAIL abort_reach: db %0d idx %0d expected 4 3", a_db, a_idx);
    end
    a_par = 1'b1;
    tick();
    a_par = 1'b0;
    a_txp = 1'b0;
    if (a_pronto) seen_pronto++;
    checks++;
    if (a_db !== 4'd0 || a_idx !== 3'd0 || a_ocup !== 1'b0 || seen_pronto != 0) begin
      errors++; $display("FAIL abort_result: db %0d idx %0d ocup %b pronto_seen %0d expected 0 0 0 0",
                         a_db, a_idx, a_ocup, seen_pronto);
    end
    tick();
    checks++;
    if (a_db !== 4'd0 || a_pronto !== 1'b0) begin
      errors++; $display("FAIL abort_stays_idle: db %0d pronto %b expected 0 0", a_db, a_pronto);
    end
    a_ini = 1'b1;
    tick();
    a_ini = 1'b0;
    tick();
    checks++;
    if (a_db !== 4'd2 || a_part !== 1'b1 || a_idx !== 3'd0) begin
      errors++; $display("FAIL abort_restart: db %0d partida %b idx %0d expected 2 1 0", a_db, a_part, a_idx);
    end
  endtask

  task automatic test_async_reset();
    tick();
    checks++;
    if (a_db !== 4'd3) begin
      errors++; $display("FAIL async_precondition: db %0d expected 3", a_db);
    end
    #2 a_rst = 1'b0;
    #1;
    checks++;
    if (a_db !== 4'd0 || a_ocup !== 1'b0 || a_part !== 1'b0 || a_pronto !== 1'b0 || a_idx !== 3'd0) begin
      errors++; $display("FAIL async_clear: db %0d ocup %b part %b pronto %b idx %0d expected all 0",
                         a_db, a_ocup, a_part, a_pronto, a_idx);
    end
    tick(); tick();
    #3 a_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (a_part !== 1'b0 || a_db !== 4'd0) begin
        errors++; $display("FAIL async_no_restart[%0d]: part %b db %0d expected 0 0", i, a_part, a_db);
      end
    end
  endtask

  task automatic test_ignored_start();
    int np = 0, last = 0, cyc = 0;
    bit done = 0, poked = 0;
    a_ini = 1'b1;
    tick();
    a_ini = 1'b0;
    while (!done && cyc < 300) begin
      cyc++;
      if (a_part) begin
        checks++;
        if (a_idx !== 3'(np)) begin
          errors++; $display("FAIL ignored_start_indice: got %0d expected %0d", a_idx, np);
        end
        np++;
        last = cyc;
      end
      if (a_pronto) done = 1;
      a_ini = 1'b0;
      if (a_db == 4'd3 && a_idx == 3'd2 && !poked) begin
        a_ini = 1'b1;
        poked = 1;
      end
      a_txp = (np > 0) && (cyc == last + 3);
      if (!done) tick();
    end
    a_ini = 1'b0;
    a_txp = 1'b0;
    checks++;
    if (!done || np != 8 || !poked) begin
      errors++; $display("FAIL ignored_start_count: pulses %0d done %0d poked %0d expected 8 1 1", np, done, poked);
    end
    tick();
    checks++;
    if (a_db !== 4'd0) begin
      errors++; $display("FAIL ignored_start_idle: db %0d expected 0", a_db);
    end
  endtask

  initial begin
    test_reset();
    test_full_message();
    test_zero_gap();
    test_early_tx_pronto();
    test_abort();
    test_async_reset();
    test_ignored_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
